// File: rtl/cpu_defs.sv
// Shared pipeline-bus definitions: bus widths and field offsets for the
// execute-to-memory and memory-to-write-back buses.
package cpu_defs;

  localparam int EX_MA_W = 71;
  localparam int MA_WB_W = 70;

  localparam int DEST_W = 5;
  localparam int WORD_W = 32;

  // execute -> memory: {res_from_mem, gr_we, dest, alu_result, pc}
  localparam int EX_RES_BIT  = 70;
  localparam int EX_WE_BIT   = 69;
  localparam int EX_DEST_LSB = 64;
  localparam int EX_ALU_LSB  = 32;
  localparam int EX_PC_LSB   = 0;

  // memory -> write-back: {gr_we, dest, final_result, pc}
  localparam int WB_WE_BIT   = 69;
  localparam int WB_DEST_LSB = 64;
  localparam int WB_RES_LSB  = 32;
  localparam int WB_PC_LSB   = 0;

  typedef struct packed {
    logic              res_from_mem;
    logic              gr_we;
    logic [DEST_W-1:0] dest;
    logic [WORD_W-1:0] alu_result;
    logic [WORD_W-1:0] pc;
  } ex_ma_t;

  typedef struct packed {
    logic              gr_we;
    logic [DEST_W-1:0] dest;
    logic [WORD_W-1:0] final_result;
    logic [WORD_W-1:0] pc;
  } ma_wb_t;

endpackage

// File: rtl/ma_rdata_hold.sv
// Keeps the SRAM read word that belongs to the instruction in the memory
// stage, so a write-back stall does not lose it when the SRAM address moves on.
module ma_rdata_hold
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              valid,
  input  logic              wb_allowin,
  input  logic              ma_allowin,
  input  logic [WORD_W-1:0] rdata,
  output logic [WORD_W-1:0] load_data
);

  logic              fresh_r;
  logic              hold_vld_r;
  logic [WORD_W-1:0] hold_data_r;

  // fresh marks the one cycle in which rdata belongs to the resident instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      fresh_r <= 1'b0;
    end else begin
      fresh_r <= accept;
    end
  end

  // capture on a stalled first cycle; any cycle that lets the stage move on releases it
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_r  <= 1'b0;
      hold_data_r <= {WORD_W{1'b0}};
    end else if (ma_allowin) begin
      hold_vld_r  <= 1'b0;
    end else if (valid & fresh_r & ~wb_allowin) begin
      hold_vld_r  <= 1'b1;
      hold_data_r <= rdata;
    end
  end

  // live SRAM word first, then the held copy; nothing meaningful otherwise
  always_comb begin
    load_data = {WORD_W{1'b0}};
    if (fresh_r) begin
      load_data = rdata;
    end else if (hold_vld_r) begin
      load_data = hold_data_r;
    end else begin
      load_data = {WORD_W{1'b0}};
    end
  end

endmodule

// File: rtl/mastage.sv
// Memory-access pipeline stage: valid/allowin handshake, result selection
// between load data and ALU result, and packing of the write-back bus.
module mastage
  import cpu_defs::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_validout,
  input  logic               wb_allowin,
  output logic               ma_allowin,
  output logic               ma_validout,
  input  logic [EX_MA_W-1:0] ex_to_ma_bus,
  input  logic [WORD_W-1:0]  data_sram_rdata,
  output logic [MA_WB_W-1:0] ma_to_wb_bus,
  output logic [DEST_W-1:0]  ma_to_id_dest
);

  logic               valid_r;
  logic [EX_MA_W-1:0] bus_r;
  logic               accept_s;
  logic               res_from_mem_s;
  logic               gr_we_s;
  logic [DEST_W-1:0]  dest_s;
  logic [WORD_W-1:0]  alu_result_s;
  logic [WORD_W-1:0]  pc_s;
  logic [WORD_W-1:0]  load_data_s;
  logic [WORD_W-1:0]  final_result_s;

  // readygo is always 1, so the stage frees up whenever write-back takes it
  assign ma_allowin  = ~valid_r | wb_allowin;
  assign accept_s    = ex_validout & ma_allowin;
  assign ma_validout = valid_r;

  // occupancy and instruction register; bubbles never overwrite the bus
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      bus_r   <= {EX_MA_W{1'b0}};
    end else begin
      if (ma_allowin) begin
        valid_r <= ex_validout;
      end
      if (accept_s) begin
        bus_r <= ex_to_ma_bus;
      end
    end
  end

  assign res_from_mem_s = bus_r[EX_RES_BIT];
  assign gr_we_s        = bus_r[EX_WE_BIT];
  assign dest_s         = bus_r[EX_DEST_LSB +: DEST_W];
  assign alu_result_s   = bus_r[EX_ALU_LSB +: WORD_W];
  assign pc_s           = bus_r[EX_PC_LSB +: WORD_W];

  ma_rdata_hold u_hold (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept_s),
    .valid      (valid_r),
    .wb_allowin (wb_allowin),
    .ma_allowin (ma_allowin),
    .rdata      (data_sram_rdata),
    .load_data  (load_data_s)
  );

  // result mux and write-back bus packing
  always_comb begin
    final_result_s = alu_result_s;
    if (res_from_mem_s) begin
      final_result_s = load_data_s;
    end else begin
      final_result_s = alu_result_s;
    end
    ma_to_wb_bus                          = {MA_WB_W{1'b0}};
    ma_to_wb_bus[WB_WE_BIT]               = gr_we_s;
    ma_to_wb_bus[WB_DEST_LSB +: DEST_W]   = dest_s;
    ma_to_wb_bus[WB_RES_LSB +: WORD_W]    = final_result_s;
    ma_to_wb_bus[WB_PC_LSB +: WORD_W]     = pc_s;
  end

  assign ma_to_id_dest = dest_s & {DEST_W{valid_r}};

endmodule

// File: tb/tb_mastage.sv
// Scoreboard bench for mastage: directed scenarios followed by random traffic.
module tb_mastage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_validout;
  logic        wb_allowin;
  logic        ma_allowin;
  logic        ma_validout;
  logic [70:0] ex_to_ma_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] ma_to_wb_bus;
  logic [4:0]  ma_to_id_dest;

  mastage dut (
    .clk             (clk),
    .rst             (rst),
    .ex_validout     (ex_validout),
    .wb_allowin      (wb_allowin),
    .ma_allowin      (ma_allowin),
    .ma_validout     (ma_validout),
    .ex_to_ma_bus    (ex_to_ma_bus),
    .data_sram_rdata (data_sram_rdata),
    .ma_to_wb_bus    (ma_to_wb_bus),
    .ma_to_id_dest   (ma_to_id_dest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [69:0] bus;
    logic [4:0]  dest;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        mon_en = 1'b0;
  logic [31:0] rd_plan = 32'h0;

  task automatic check(input string nm, input logic [69:0] act, input logic [69:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [70:0] mk(input logic res, input logic we, input logic [4:0] dest,
                                     input logic [31:0] alu, input logic [31:0] pc);
    return {res, we, dest, alu, pc};
  endfunction

  // What write-back must see: a load returns the word read the cycle after entry
  function automatic exp_t predict(input logic [70:0] b, input logic [31:0] rd);
    exp_t e;
    e.bus  = {b[69], b[68:64], (b[70] ? rd : b[63:32]), b[31:0]};
    e.dest = b[68:64];
    return e;
  endfunction

  // rd_nxt is the SRAM word presented in the cycle after this one
  task automatic step(input logic ev, input logic wba, input logic [70:0] bus, input logic [31:0] rd_nxt);
    @(posedge clk);
    #1;
    ex_validout     = ev;
    wb_allowin      = wba;
    ex_to_ma_bus    = bus;
    data_sram_rdata = rd_plan;
    rd_plan         = rd_nxt;
  endtask

  task automatic check_empty(input string nm);
    check({nm, "_validout"}, {69'd0, ma_validout}, 70'd0);
    check({nm, "_allowin"},  {69'd0, ma_allowin},  70'd1);
    check({nm, "_id_dest"},  {65'd0, ma_to_id_dest}, 70'd0);
    check({nm, "_wb_bus"},   ma_to_wb_bus, 70'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    mon_en      = 1'b0;
    rst         = 1'b1;
    ex_validout = 1'b0;
    wb_allowin  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    check_empty("reset");
    check("reset_hold_vld", {69'd0, dut.u_hold.hold_vld_r}, 70'd0);
    mon_en = 1'b1;
  endtask

  // Monitor: a stage holds at most one instruction; compare on every transfer
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_allow;
      exp_allow = (q.size() == 0) || wb_allowin;
      check("allowin",  {69'd0, ma_allowin}, {69'd0, exp_allow});
      check("validout", {69'd0, ma_validout}, {69'd0, (q.size() != 0)});
      check("id_dest",  {65'd0, ma_to_id_dest}, {65'd0, (q.size() != 0) ? q[0].dest : 5'd0});
      if (q.size() != 0 && wb_allowin) begin
        exp_t e;
        e = q.pop_front();
        check("wb_bus", ma_to_wb_bus, e.bus);
      end
      if (ex_validout && exp_allow) begin
        q.push_back(predict(ex_to_ma_bus, rd_plan));
      end
    end
  end

  initial begin
    rst             = 1'b1;
    ex_validout     = 1'b0;
    wb_allowin      = 1'b0;
    ex_to_ma_bus    = 71'd0;
    data_sram_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_empty("init");
    mon_en = 1'b1;

    // single load
    step(1'b1, 1'b1, mk(1'b1, 1'b1, 5'd4, 32'h1000, 32'h1c000010), 32'hDEADBEEF);
    step(1'b0, 1'b1, 71'd0, 32'h0);
    step(1'b0, 1'b1, 71'd0, 32'h0);

    // ALU op ignores rdata
    step(1'b1, 1'b1, mk(1'b0, 1'b1, 5'd3, 32'h7, 32'h1c000020), 32'h55555555);
    step(1'b0, 1'b1, 71'd0, 32'h0);
    step(1'b0, 1'b1, 71'd0, 32'h0);

    // load under a three-cycle stall
    step(1'b1, 1'b1, mk(1'b1, 1'b1, 5'd7, 32'h2000, 32'h1c000030), 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 71'd0, 32'hFFFFFFFF);
      @(negedge clk);
      check("stall_result", {38'd0, ma_to_wb_bus[63:32]}, {38'd0, 32'h12345678});
      if (i > 0) check("stall_hold_vld", {69'd0, dut.u_hold.hold_vld_r}, 70'd1);
    end
    step(1'b0, 1'b1, 71'd0, 32'h0);

    // back-to-back loads
    step(1'b1, 1'b1, mk(1'b1, 1'b1, 5'd10, 32'h3000, 32'h1c000040), 32'hA);
    step(1'b1, 1'b1, mk(1'b1, 1'b1, 5'd11, 32'h3004, 32'h1c000044), 32'hB);
    @(negedge clk);
    check("b2b_hold_vld_a", {69'd0, dut.u_hold.hold_vld_r}, 70'd0);
    step(1'b0, 1'b1, 71'd0, 32'h0);
    @(negedge clk);
    check("b2b_hold_vld_b", {69'd0, dut.u_hold.hold_vld_r}, 70'd0);
    step(1'b0, 1'b1, 71'd0, 32'h0);

    // stalled load drains on the same edge an ALU op enters
    step(1'b1, 1'b1, mk(1'b1, 1'b1, 5'd12, 32'h4000, 32'h1c000050), 32'hCAFEF00D);
    step(1'b0, 1'b0, 71'd0, 32'h11111111);
    step(1'b0, 1'b0, 71'd0, 32'h22222222);
    step(1'b1, 1'b1, mk(1'b0, 1'b1, 5'd9, 32'h55, 32'h1c000054), 32'h33333333);
    step(1'b0, 1'b1, 71'd0, 32'h0);
    @(negedge clk);
    check("newentry_hold_vld", {69'd0, dut.u_hold.hold_vld_r}, 70'd0);
    step(1'b0, 1'b1, 71'd0, 32'h0);

    // reset in the middle of a stalled load
    step(1'b1, 1'b1, mk(1'b1, 1'b1, 5'd13, 32'h5000, 32'h1c000060), 32'h87654321);
    step(1'b0, 1'b0, 71'd0, 32'h0);
    step(1'b0, 1'b0, 71'd0, 32'h0);
    do_reset();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0,
           {$urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, 5'($urandom), $urandom, $urandom},
           $urandom);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 71'd0, 32'h0);
    @(negedge clk);
    check("drained", {38'd0, 32'(q.size())}, 70'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
